// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scan controller for an up-to-8-digit seven-segment
//   display. Drives the digit-mux select, registers the returned byte onto
//   the active-low segment pins, and drives the active-low anodes.
//
//   Optional feature macro: SCAN_BLANKING_EN
//     When defined, each digit dwell begins with BLANK_CYCLES clocks of
//     dark display (anodes and segments off) to suppress ghosting while
//     the mux settles. The total dwell per digit stays DIV_COUNT clocks.
//     When undefined, the digit is lit for its whole dwell.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_WIDTH    = 17,
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [7:0] mux_byte,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

`ifdef SCAN_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [DIV_WIDTH-1:0] LAST_CNT   = DIV_WIDTH'(DIV_COUNT - 1);
  localparam logic [DIV_WIDTH-1:0] LAST_BLANK = DIV_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [2:0]           LAST_SEL   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] pres, pres_n;
  logic [2:0]           sel_n;
  logic [7:0]           an_n, seg_n;
  logic                 ft_n;
  logic                 lit;

  // Anode pattern for one digit: a single low bit, or all-off when masked.
  function automatic logic [7:0] digit_anode(input logic [2:0] s,
                                             input logic [7:0] mask);
    logic [7:0] onehot;
    onehot = 8'b1 << s;
    return mask[s] ? ~onehot : 8'hFF;
  endfunction

  // Next-state, prescaler, select advance and output pattern selection.
  always_comb begin
    state_n = state;
    pres_n  = pres;
    sel_n   = sel;
    ft_n    = 1'b0;

    case (state)
      IDLE: begin
        pres_n = '0;
        sel_n  = '0;
        if (en) state_n = BLANK_EN ? BLANK : SHOW;
      end
      SHOW, BLANK: begin
        if (pres == LAST_CNT) begin
          // End of dwell: move to the next digit, wrapping at the last one.
          pres_n  = '0;
          sel_n   = (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
          ft_n    = (sel == LAST_SEL);
          state_n = BLANK_EN ? BLANK : SHOW;
        end else begin
          pres_n = pres + 1'b1;
          if (state == BLANK && pres == LAST_BLANK) state_n = SHOW;
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping enable wins over everything and parks the scanner at digit 0.
    if (!en) begin
      state_n = IDLE;
      pres_n  = '0;
      sel_n   = '0;
      ft_n    = 1'b0;
    end

    // Light the display only while scanning and not entering dead time.
    // The anode uses the current select, so an/seg lag sel by one clock.
    lit   = (state != IDLE) && (state_n == SHOW);
    an_n  = lit ? digit_anode(sel, digit_mask) : 8'hFF;
    seg_n = lit ? ~mux_byte : 8'hFF;
  end

  // State, prescaler and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pres       <= '0;
      sel        <= '0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      pres       <= pres_n;
      sel        <= sel_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_tick <= ft_n;
    end
  end

endmodule
